writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/cpu_parameters.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/writeback_arbiter.sv | 118 +++++++++++
 tb/tb_writeback_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_parameters.sv
// Shared CPU-wide constants and types: data width, writeback port indices and
// the writeback buffer entry layout.
package cpu_parameters;

  localparam int xlen = 32;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  typedef struct packed {
    logic            v;
    logic [4:0]      rd;
    logic [xlen-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above the last
// granted index (wrapping), returning a one-hot grant.
module rr_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant
);

  logic found;
  int   idx;

  // Scan starts one past last_grant so the previous winner is considered last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_grant) + i) % NUM_PORTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one result buffer per source port, round-robin retirement
// into the register file write port. Optional macro: WB_INSTRET_COUNTER_EN.
module writeback_arbiter
  import cpu_parameters::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           wb_v_i,
  output logic [NUM_PORTS-1:0]           wb_ready_o,
  input  logic [NUM_PORTS-1:0][4:0]      wb_rd_i,
  input  logic [NUM_PORTS-1:0][xlen-1:0] wb_data_i,
  input  logic                           flush,
  output logic                           res_v,
  output logic [4:0]                     res_adr,
  output logic [xlen-1:0]                res_data,
  output logic                           instret_o
`ifdef WB_INSTRET_COUNTER_EN
  ,
  output logic [63:0]                    minstret_o
`endif
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  wb_entry_t              buf_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]   buf_v;
  logic [NUM_PORTS-1:0]   rr_grant;
  logic [NUM_PORTS-1:0]   grant;
  logic [PTR_W-1:0]       last_grant;
  logic                   gnt_any;
  logic [PTR_W-1:0]       gnt_idx;
  logic [4:0]             gnt_rd;
  logic [xlen-1:0]        gnt_data;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      buf_v[p] = buf_q[p].v;
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req        (buf_v),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

  // A flush cycle suppresses the grant so nothing retires while buffers drop.
  assign grant      = flush ? '0 : rr_grant;
  assign wb_ready_o = ~buf_v | grant;

  always_comb begin
    gnt_any  = |grant;
    gnt_idx  = '0;
    gnt_rd   = '0;
    gnt_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        gnt_idx  = PTR_W'(p);
        gnt_rd   = buf_q[p].rd;
        gnt_data = buf_q[p].data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        buf_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (flush) begin
          buf_q[p].v <= 1'b0;
        end else if (wb_v_i[p] && wb_ready_o[p]) begin
          buf_q[p] <= {1'b1, wb_rd_i[p], wb_data_i[p]};
        end else if (grant[p]) begin
          buf_q[p].v <= 1'b0;
        end
      end
    end
  end

  // Writes to x0 still retire, they just never assert the write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_v      <= 1'b0;
      res_adr    <= '0;
      res_data   <= '0;
      instret_o  <= 1'b0;
      last_grant <= PTR_W'(NUM_PORTS - 1);
    end else if (gnt_any) begin
      res_v      <= (gnt_rd != 5'd0);
      res_adr    <= gnt_rd;
      res_data   <= gnt_data;
      instret_o  <= 1'b1;
      last_grant <= gnt_idx;
    end else begin
      res_v      <= 1'b0;
      instret_o  <= 1'b0;
    end
  end

`ifdef WB_INSTRET_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minstret_o <= '0;
    end else if (instret_o) begin
      minstret_o <= minstret_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, random
// traffic against a queue-level model, and asynchronous reset checks.
module tb_writeback_arbiter;
  import cpu_parameters::*;

  localparam int NP = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0]           wb_v_i;
  logic [NP-1:0]           wb_ready_o;
  logic [NP-1:0][4:0]      wb_rd_i;
  logic [NP-1:0][xlen-1:0] wb_data_i;
  logic                    flush;
  logic                    res_v;
  logic [4:0]              res_adr;
  logic [xlen-1:0]         res_data;
  logic                    instret_o;
`ifdef WB_INSTRET_COUNTER_EN
  logic [63:0]             minstret_o;
`endif

  always #5 clk = ~clk;

  writeback_arbiter #(.NUM_PORTS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_v_i     (wb_v_i),
    .wb_ready_o (wb_ready_o),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .flush      (flush),
    .res_v      (res_v),
    .res_adr    (res_adr),
    .res_data   (res_data),
    .instret_o  (instret_o)
`ifdef WB_INSTRET_COUNTER_EN
    ,
    .minstret_o (minstret_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending result per port plus the last winner index.
  bit              m_v   [NP];
  logic [4:0]      m_rd  [NP];
  logic [xlen-1:0] m_dat [NP];
  int              m_last;
  logic            m_res_v, m_inst;
  logic [4:0]      m_adr;
  logic [xlen-1:0] m_data;
  longint unsigned m_cnt;
  logic [NP-1:0]   last_ready;

  typedef struct {
    logic [NP-1:0]           v;
    logic [NP-1:0][4:0]      rd;
    logic [NP-1:0][xlen-1:0] data;
    logic                    fl;
    logic [NP-1:0]           ready;
    logic                    res_v;
    logic                    inst;
    logic                    care;
    logic [4:0]              adr;
    logic [xlen-1:0]         dat;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic [NP-1:0] v, input logic [NP-1:0][4:0] rd,
                              input logic [NP-1:0][xlen-1:0] data, input logic fl,
                              input logic [NP-1:0] ready, input logic rv, input logic inst,
                              input logic care, input logic [4:0] adr, input logic [xlen-1:0] dat);
    vec_t r;
    r.v = v; r.rd = rd; r.data = data; r.fl = fl; r.ready = ready;
    r.res_v = rv; r.inst = inst; r.care = care; r.adr = adr; r.dat = dat;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < NP; p++) begin
      m_v[p] = 1'b0; m_rd[p] = '0; m_dat[p] = '0;
    end
    m_last  = NP - 1;
    m_res_v = 1'b0; m_inst = 1'b0; m_adr = '0; m_data = '0;
    m_cnt   = 0;
  endtask

  function automatic int modelGrant(input logic fl);
    if (fl) return -1;
    for (int k = 1; k <= NP; k++) begin
      if (m_v[(m_last + k) % NP]) return (m_last + k) % NP;
    end
    return -1;
  endfunction

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic applyStimulus(input logic [NP-1:0] v, input logic [NP-1:0][4:0] rd,
                               input logic [NP-1:0][xlen-1:0] data, input logic fl,
                               input string tag);
    int            g;
    logic [NP-1:0] exp_rdy;
    wb_v_i = v; wb_rd_i = rd; wb_data_i = data; flush = fl;
    #1;
    g = modelGrant(fl);
    for (int p = 0; p < NP; p++) exp_rdy[p] = !m_v[p] || (p == g);
    last_ready = wb_ready_o;
    checkOutput({tag, " ready"}, wb_ready_o, exp_rdy);
    @(posedge clk);
    if (g >= 0) begin
      m_res_v = (m_rd[g] != 5'd0);
      m_adr   = m_rd[g];
      m_data  = m_dat[g];
      m_inst  = 1'b1;
      m_last  = g;
      m_cnt++;
    end else begin
      m_res_v = 1'b0;
      m_inst  = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      if (fl) m_v[p] = 1'b0;
      else if (v[p] && exp_rdy[p]) begin
        m_v[p] = 1'b1; m_rd[p] = rd[p]; m_dat[p] = data[p];
      end else if (p == g) m_v[p] = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, " res_v"}, res_v, m_res_v);
    checkOutput({tag, " instret"}, instret_o, m_inst);
    checkOutput({tag, " res_adr"}, res_adr, m_adr);
    checkOutput({tag, " res_data"}, res_data, m_data);
`ifdef WB_INSTRET_COUNTER_EN
    checkOutput({tag, " minstret"}, minstret_o, m_cnt);
`endif
  endtask

  task automatic idle(input string tag);
    applyStimulus('0, '0, '0, 1'b0, tag);
  endtask

  task automatic doReset();
    rst = 1'b1; wb_v_i = '0; wb_rd_i = '0; wb_data_i = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset res_v", res_v, 0);
    checkOutput("reset res_adr", res_adr, 0);
    checkOutput("reset res_data", res_data, 0);
    checkOutput("reset instret", instret_o, 0);
    checkOutput("reset ready", wb_ready_o, 3'b111);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [NP-1:0][4:0]      r_rd;
    logic [NP-1:0][xlen-1:0] r_dat;

    // Contention from reset, single write, x0, flush, then back-to-back.
    tbl[0]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, '0, '0, 0, 3'b001, 1, 1, 1, 5'd1, 32'h11);
    tbl[2]  = mk(0, '0, '0, 0, 3'b011, 1, 1, 1, 5'd2, 32'h22);
    tbl[3]  = mk(0, '0, '0, 0, 3'b111, 1, 1, 1, 5'd3, 32'h33);
    tbl[4]  = mk(0, '0, '0, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[5]  = mk(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, '0, '0, 0, 3'b111, 1, 1, 1, 5'd5, 32'hDEADBEEF);
    tbl[7]  = mk(0, '0, '0, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[8]  = mk(3'b010, '0, {32'd0, 32'h12, 32'd0}, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, '0, '0, 0, 3'b111, 0, 1, 1, 5'd0, 32'h12);
    tbl[10] = mk(0, '0, '0, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[11] = mk(3'b101, {5'd9, 5'd0, 5'd7}, {32'h90, 32'd0, 32'h70}, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, '0, '0, 1, 3'b010, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, '0, '0, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[14] = mk(3'b100, {5'd10, 10'd0}, {32'hA0, 64'd0}, 0, 3'b111, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, '0, '0, 0, 3'b111, 1, 1, 1, 5'd10, 32'hA0);
    tbl[16] = mk(0, '0, '0, 0, 3'b111, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tbl[17 + k] = mk(3'b001, {10'd0, 5'(k + 1)}, {64'd0, 32'(100 + k)}, 0, 3'b111,
                       (k != 0), (k != 0), (k != 0), 5'(k), 32'(100 + k - 1));
    end
    tbl[25] = mk(0, '0, '0, 0, 3'b111, 1, 1, 1, 5'd8, 32'd107);
    tbl[26] = mk(0, '0, '0, 0, 3'b111, 0, 0, 0, 0, 0);

    doReset();

    for (int i = 0; i < 27; i++) begin
      applyStimulus(tbl[i].v, tbl[i].rd, tbl[i].data, tbl[i].fl, $sformatf("tbl%0d", i));
      checkOutput($sformatf("tbl%0d const ready", i), last_ready, tbl[i].ready);
      checkOutput($sformatf("tbl%0d const res_v", i), res_v, tbl[i].res_v);
      checkOutput($sformatf("tbl%0d const instret", i), instret_o, tbl[i].inst);
      if (tbl[i].care) begin
        checkOutput($sformatf("tbl%0d const res_adr", i), res_adr, tbl[i].adr);
        checkOutput($sformatf("tbl%0d const res_data", i), res_data, tbl[i].dat);
      end
    end

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        r_rd[p]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r_dat[p] = $urandom;
      end
      applyStimulus(3'($urandom_range(0, 7)), r_rd, r_dat, ($urandom_range(0, 15) == 0),
                    $sformatf("rnd%0d", c));
    end

    // Asynchronous reset in the middle of a busy stream.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b111, {5'd21, 5'd22, 5'd23}, {32'hC3, 32'hC2, 32'hC1}, 1'b0, "prerst");
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst res_v", res_v, 0);
    checkOutput("async rst res_adr", res_adr, 0);
    checkOutput("async rst res_data", res_data, 0);
    checkOutput("async rst instret", instret_o, 0);
    wb_v_i = '0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("post rst ready", wb_ready_o, 3'b111);
    @(negedge clk);
    idle("post rst idle");

`ifdef WB_INSTRET_COUNTER_EN
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b001, {10'd0, ((i == 3 || i == 7) ? 5'd0 : 5'(i + 1))},
                    {64'd0, 32'(i)}, 1'b0, $sformatf("cnt%0d", i));
    end
    idle("cnt drain0");
    idle("cnt drain1");
    checkOutput("minstret after 10", minstret_o, 64'd10);
    #2 rst = 1'b1;
    #1;
    checkOutput("minstret async rst", minstret_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
